// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer for the 5-stage rv32i pipeline
module pipeline_ctrl #(
    parameter int CNT_W = 32,
    parameter int WDOG  = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_resp,
    input  logic             dmem_active,
    input  logic             dmem_resp,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_br_taken,
    input  logic             clr_cnt,
    output logic             pc_load,
    output logic             if_id_load,
    output logic             id_ex_load,
    output logic             ex_mem_load,
    output logic             mem_wb_load,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_timeout
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_DROP = 1'b1
    } state_t;

    localparam int WD_W = $clog2(WDOG + 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(WDOG);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;
    logic [WD_W-1:0]   r_wdog;
    logic              r_mem_timeout;

    logic w_mem_stall;
    logic w_hazard;
    logic w_fetch_ok;
    logic w_stall_evt;
    logic w_flush_evt;
    logic w_pc_load;
    logic w_if_id_load;
    logic w_id_ex_load;
    logic w_ex_mem_load;
    logic w_mem_wb_load;
    logic w_if_id_flush;
    logic w_id_ex_flush;

    assign w_mem_stall = dmem_active & ~dmem_resp;
    assign w_hazard    = ex_is_load & (ex_rd != 5'd0) &
                         ((id_use_rs1 & (id_rs1 == ex_rd)) |
                          (id_use_rs2 & (id_rs2 == ex_rd)));
    assign w_fetch_ok  = imem_resp & (r_state == S_RUN);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_stall_evt   = 1'b0;
        w_flush_evt   = 1'b0;
        w_pc_load     = 1'b1;
        w_if_id_load  = 1'b1;
        w_id_ex_load  = 1'b1;
        w_ex_mem_load = 1'b1;
        w_mem_wb_load = 1'b1;
        w_if_id_flush = 1'b0;
        w_id_ex_flush = 1'b0;

        if (w_mem_stall) begin
            w_pc_load     = 1'b0;
            w_if_id_load  = 1'b0;
            w_id_ex_load  = 1'b0;
            w_ex_mem_load = 1'b0;
            w_mem_wb_load = 1'b0;
            w_stall_evt   = 1'b1;
        end else if (ex_br_taken) begin
            w_if_id_flush = 1'b1;
            w_id_ex_flush = 1'b1;
            w_flush_evt   = 1'b1;
        end else if (w_hazard) begin
            w_pc_load     = 1'b0;
            w_if_id_load  = 1'b0;
            w_id_ex_flush = 1'b1;
            w_stall_evt   = 1'b1;
        end else if (!w_fetch_ok) begin
            w_pc_load     = 1'b0;
            w_if_id_flush = 1'b1;
            w_stall_evt   = 1'b1;
        end

        // A stale fetch is consumed by any response, even during a freeze,
        // unless a fresh redirect leaves yet another fetch outstanding.
        case (r_state)
            S_RUN: begin
                if (w_flush_evt && !imem_resp) begin
                    w_next = S_DROP;
                end
            end
            S_DROP: begin
                if (imem_resp && !w_flush_evt) begin
                    w_next = S_RUN;
                end
            end
            default: w_next = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (clr_cnt) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush_evt && (r_flush_cnt != CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wdog <= '0;
        end else if (!w_mem_stall) begin
            r_wdog <= '0;
        end else if (r_wdog != WD_MAX) begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    // Sets on the edge where the consecutive-stall count becomes WDOG.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_mem_timeout <= 1'b0;
        end else if (clr_cnt) begin
            r_mem_timeout <= 1'b0;
        end else if (w_mem_stall && ((r_wdog == WD_LAST) || (r_wdog == WD_MAX))) begin
            r_mem_timeout <= 1'b1;
        end
    end

    assign pc_load     = rst & w_pc_load;
    assign if_id_load  = rst & w_if_id_load;
    assign id_ex_load  = rst & w_id_ex_load;
    assign ex_mem_load = rst & w_ex_mem_load;
    assign mem_wb_load = rst & w_mem_wb_load;
    assign if_id_flush = rst & w_if_id_flush;
    assign id_ex_flush = rst & w_id_ex_flush;
    assign stall_cnt   = r_stall_cnt;
    assign flush_cnt   = r_flush_cnt;
    assign mem_timeout = r_mem_timeout;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

    localparam int CNT_W = 3;
    localparam int WDOG  = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, imem_resp, dmem_active, dmem_resp, ex_is_load;
    logic [4:0]       ex_rd, id_rs1, id_rs2;
    logic             id_use_rs1, id_use_rs2, ex_br_taken, clr_cnt;
    logic             pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
    logic             if_id_flush, id_ex_flush, mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    pipeline_ctrl #(.CNT_W(CNT_W), .WDOG(WDOG)) dut (
        .clk(clk), .rst(rst), .imem_resp(imem_resp), .dmem_active(dmem_active),
        .dmem_resp(dmem_resp), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1),
        .id_use_rs2(id_use_rs2), .ex_br_taken(ex_br_taken), .clr_cnt(clr_cnt),
        .pc_load(pc_load), .if_id_load(if_id_load), .id_ex_load(id_ex_load),
        .ex_mem_load(ex_mem_load), .mem_wb_load(mem_wb_load),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
    );

    typedef struct {
        logic       rst_n, imem, dact, dresp, ldx;
        logic [4:0] rd, rs1, rs2;
        logic       u1, u2, br, clr;
    } vec_t;

    typedef struct {
        vec_t       v;
        logic [4:0] ld;
        logic [1:0] fl;
        int         sc;
        int         fc;
    } tv_t;

    int n_pass = 0;
    int n_tot  = 0;

    int         m_sc, m_fc, m_wd;
    bit         m_pend, m_to;
    logic [4:0] m_ld;
    logic [1:0] m_fl;

    function automatic vec_t mk(logic r, logic im, logic da, logic dr, logic lx,
                                logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                logic u1, logic u2, logic br, logic cl);
        vec_t v;
        v.rst_n = r; v.imem = im; v.dact = da; v.dresp = dr; v.ldx = lx;
        v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.u1 = u1; v.u2 = u2;
        v.br = br; v.clr = cl;
        return v;
    endfunction

    function automatic tv_t mkt(vec_t v, logic [4:0] ld, logic [1:0] fl, int sc, int fc);
        tv_t t;
        t.v = v; t.ld = ld; t.fl = fl; t.sc = sc; t.fc = fc;
        return t;
    endfunction

    task automatic drive(vec_t v);
        rst = v.rst_n; imem_resp = v.imem; dmem_active = v.dact; dmem_resp = v.dresp;
        ex_is_load = v.ldx; ex_rd = v.rd; id_rs1 = v.rs1; id_rs2 = v.rs2;
        id_use_rs1 = v.u1; id_use_rs2 = v.u2; ex_br_taken = v.br; clr_cnt = v.clr;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: which rule wins decides the strobes; a pending-stale-fetch bit
    // stands in for the FSM; counters are plain saturating integers.
    task automatic model_step(vec_t v);
        bit ms, hz;
        int rule;
        ms = v.dact & ~v.dresp;
        hz = v.ldx && (v.rd != 0) && ((v.u1 && v.rs1 == v.rd) || (v.u2 && v.rs2 == v.rd));
        if (ms)                         rule = 1;
        else if (v.br)                  rule = 2;
        else if (hz)                    rule = 3;
        else if (!v.imem || m_pend)     rule = 4;
        else                            rule = 5;
        case (rule)
            1: begin m_ld = 5'b00000; m_fl = 2'b00; end
            2: begin m_ld = 5'b11111; m_fl = 2'b11; end
            3: begin m_ld = 5'b00111; m_fl = 2'b01; end
            4: begin m_ld = 5'b01111; m_fl = 2'b10; end
            default: begin m_ld = 5'b11111; m_fl = 2'b00; end
        endcase
        if (!v.rst_n) begin
            m_ld = 5'b0; m_fl = 2'b0;
            m_pend = 0; m_sc = 0; m_fc = 0; m_wd = 0; m_to = 0;
        end else begin
            if (m_pend) begin
                if (v.imem && rule != 2) m_pend = 0;
            end else if (rule == 2 && !v.imem) begin
                m_pend = 1;
            end
            m_wd = ms ? ((m_wd + 1 > WDOG) ? WDOG : m_wd + 1) : 0;
            if (v.clr) begin
                m_sc = 0; m_fc = 0; m_to = 0;
            end else begin
                if ((rule == 1 || rule == 3 || rule == 4) && m_sc < CMAX) m_sc++;
                if (rule == 2 && m_fc < CMAX) m_fc++;
                if (ms && m_wd >= WDOG) m_to = 1;
            end
        end
    endtask

    function automatic logic [4:0] get_ld();
        return {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load};
    endfunction

    function automatic logic [1:0] get_fl();
        return {if_id_flush, id_ex_flush};
    endfunction

    task automatic step(vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        model_step(v);
    endtask

    task automatic do_reset();
        vec_t r;
        r = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(r);
        chk("reset_loads", {27'd0, get_ld()}, 32'd0);
        step(r);
        chk("reset_flush", {30'd0, get_fl()}, 32'd0);
    endtask

    tv_t  tbl[$];
    vec_t nv;

    initial begin
        nv = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) tbl.push_back(mkt(nv, 5'b11111, 2'b00, 0, 0));
        tbl.push_back(mkt(mk(1,1,0,0,1,5,0,5,0,1,0,0), 5'b00111, 2'b01, 0, 0));
        tbl.push_back(mkt(mk(1,1,0,0,1,0,0,0,0,1,0,0), 5'b11111, 2'b00, 1, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mkt(mk(1,1,1,0,0,0,0,0,0,0,0,0), 5'b00000, 2'b00, 1 + i, 0));
        tbl.push_back(mkt(mk(1,1,1,1,0,0,0,0,0,0,0,0), 5'b11111, 2'b00, 4, 0));
        tbl.push_back(mkt(mk(1,1,1,0,1,5,0,5,0,1,0,0), 5'b00000, 2'b00, 4, 0));
        tbl.push_back(mkt(mk(1,1,1,1,1,5,0,5,0,1,0,0), 5'b00111, 2'b01, 5, 0));
        tbl.push_back(mkt(mk(1,0,0,0,0,0,0,0,0,0,1,0), 5'b11111, 2'b11, 6, 0));
        tbl.push_back(mkt(mk(1,0,0,0,0,0,0,0,0,0,0,0), 5'b01111, 2'b10, 6, 1));
        tbl.push_back(mkt(nv,                          5'b01111, 2'b10, 7, 1));
        tbl.push_back(mkt(nv,                          5'b11111, 2'b00, 7, 1));
        tbl.push_back(mkt(mk(1,0,0,0,0,0,0,0,0,0,0,1), 5'b01111, 2'b10, 7, 1));
        tbl.push_back(mkt(nv,                          5'b11111, 2'b00, 0, 0));

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].v);
            chk($sformatf("tbl%0d_loads", i), {27'd0, get_ld()}, {27'd0, tbl[i].ld});
            chk($sformatf("tbl%0d_flush", i), {30'd0, get_fl()}, {30'd0, tbl[i].fl});
            chk($sformatf("tbl%0d_stall_cnt", i), {29'd0, stall_cnt}, tbl[i].sc);
            chk($sformatf("tbl%0d_flush_cnt", i), {29'd0, flush_cnt}, tbl[i].fc);
        end

        // Watchdog: timeout visible from the 5th stall cycle (after 4 stall edges).
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            step(mk(1,1,1,0,0,0,0,0,0,0,0,0));
            chk($sformatf("wdog_stall%0d", k), {31'd0, mem_timeout}, (k >= 5) ? 32'd1 : 32'd0);
        end
        step(nv);
        chk("wdog_sticky", {31'd0, mem_timeout}, 32'd1);
        chk("wdog_stall_cnt", {29'd0, stall_cnt}, 32'd6);
        step(mk(1,1,0,0,0,0,0,0,0,0,0,1));
        step(nv);
        chk("wdog_clr_to", {31'd0, mem_timeout}, 32'd0);
        chk("wdog_clr_cnt", {29'd0, stall_cnt}, 32'd0);

        // Reset while a stale fetch is pending returns to normal fetching.
        step(mk(1,0,0,0,0,0,0,0,0,0,1,0));
        chk("drop_redirect", {30'd0, get_fl()}, 32'd3);
        step(mk(0,0,0,0,0,0,0,0,0,0,0,0));
        chk("drop_rst_loads", {27'd0, get_ld()}, 32'd0);
        step(nv);
        chk("drop_rst_run", {27'd0, get_ld()}, 32'h1f);

        do_reset();
        for (int i = 0; i < 3000; i++) begin
            vec_t v;
            int   sc0, fc0;
            bit   to0;
            v = mk(($urandom_range(49) != 0), ($urandom_range(2) != 0),
                   ($urandom_range(2) == 0), $urandom_range(1),
                   $urandom_range(1), 5'($urandom_range(3)), 5'($urandom_range(3)),
                   5'($urandom_range(3)), $urandom_range(1), $urandom_range(1),
                   ($urandom_range(5) == 0), ($urandom_range(29) == 0));
            sc0 = m_sc; fc0 = m_fc; to0 = m_to;
            step(v);
            chk("rnd_loads", {27'd0, get_ld()}, {27'd0, m_ld});
            chk("rnd_flush", {30'd0, get_fl()}, {30'd0, m_fl});
            chk("rnd_stall_cnt", {29'd0, stall_cnt}, sc0);
            chk("rnd_flush_cnt", {29'd0, flush_cnt}, fc0);
            chk("rnd_timeout", {31'd0, mem_timeout}, {31'd0, to0});
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
